// File: rtl/gray_input_controller.sv
// Gray input sequencer: picks the 4-bit Gray code from debounced switches, an
// internal timed counter or a frozen value, cycled by a debounced mode button.
module gray_input_controller #(
    parameter int DB_CNT   = 270000,
    parameter int STEP_CNT = 13500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_gray,
    input  logic       btn_mode,
    output logic [3:0] gray_out,
    output logic       gray_upd,
    output logic [1:0] mode
);
    localparam int DBW = $clog2(DB_CNT);
    localparam int STW = $clog2(STEP_CNT);
    // Stable value is taken on the DB_CNT-th matching sample; the count then parks.
    localparam logic [DBW-1:0] DB_ACC    = DBW'(DB_CNT - 2);
    localparam logic [DBW-1:0] DB_SAT    = DBW'(DB_CNT - 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(STEP_CNT - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        HOLD   = 2'b10
    } mode_e;

    logic [3:0]     sw_meta_q, sw_sync_q;
    logic [3:0]     sw_cand_q, sw_cand_d;
    logic [DBW-1:0] sw_cnt_q,  sw_cnt_d;
    logic [3:0]     sw_db_q,   sw_db_d;

    logic           btn_meta_q, btn_sync_q;
    logic           btn_cand_q, btn_cand_d;
    logic [DBW-1:0] btn_cnt_q,  btn_cnt_d;
    logic           btn_db_q,   btn_db_d;
    logic           press_q,    press_d;

    mode_e          state_q, state_d;
    logic [3:0]     gray_q,  gray_d;
    logic           upd_q,   upd_d;
    logic [3:0]     bin_q,   bin_d;
    logic [3:0]     bin_inc;
    logic [STW-1:0] step_q,  step_d;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always_comb begin
        sw_cand_d = sw_cand_q;
        sw_cnt_d  = sw_cnt_q;
        sw_db_d   = sw_db_q;
        if (sw_sync_q != sw_cand_q) begin
            sw_cand_d = sw_sync_q;
            sw_cnt_d  = '0;
        end else if (sw_cnt_q != DB_SAT) begin
            sw_cnt_d = sw_cnt_q + 1'b1;
            if (sw_cnt_q == DB_ACC) sw_db_d = sw_cand_q;
        end
    end

    always_comb begin
        btn_cand_d = btn_cand_q;
        btn_cnt_d  = btn_cnt_q;
        btn_db_d   = btn_db_q;
        if (btn_sync_q != btn_cand_q) begin
            btn_cand_d = btn_sync_q;
            btn_cnt_d  = '0;
        end else if (btn_cnt_q != DB_SAT) begin
            btn_cnt_d = btn_cnt_q + 1'b1;
            if (btn_cnt_q == DB_ACC) btn_db_d = btn_cand_q;
        end
        press_d = btn_db_d & ~btn_db_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw_cand_q  <= '0;
            sw_cnt_q   <= '0;
            sw_db_q    <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_cand_q <= 1'b0;
            btn_cnt_q  <= '0;
            btn_db_q   <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sw_meta_q  <= sw_gray;
            sw_sync_q  <= sw_meta_q;
            sw_cand_q  <= sw_cand_d;
            sw_cnt_q   <= sw_cnt_d;
            sw_db_q    <= sw_db_d;
            btn_meta_q <= btn_mode;
            btn_sync_q <= btn_meta_q;
            btn_cand_q <= btn_cand_d;
            btn_cnt_q  <= btn_cnt_d;
            btn_db_q   <= btn_db_d;
            press_q    <= press_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MANUAL;
            gray_q  <= '0;
            upd_q   <= 1'b0;
            bin_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            upd_q   <= upd_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
        end
    end

    // A press always wins: it suppresses both the switch follow and the AUTO step.
    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        bin_d   = bin_q;
        step_d  = step_q;
        bin_inc = bin_q + 4'd1;
        case (state_q)
            MANUAL: begin
                if (press_q) begin
                    state_d = AUTO;
                    bin_d   = gray2bin(gray_q);
                    step_d  = '0;
                end else begin
                    gray_d = sw_db_d;
                end
            end
            AUTO: begin
                if (press_q) begin
                    state_d = HOLD;
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    bin_d  = bin_inc;
                    gray_d = bin_inc ^ (bin_inc >> 1);
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            HOLD: begin
                if (press_q) state_d = MANUAL;
            end
            default: state_d = MANUAL;
        endcase
        upd_d = (gray_d != gray_q);
    end

    assign gray_out = gray_q;
    assign gray_upd = upd_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_gray_input_controller.sv
// Directed bench for gray_input_controller with DB_CNT=4, STEP_CNT=8.
module tb_gray_input_controller;
    localparam int DB = 4;
    localparam int ST = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_gray = 4'b0000;
    logic       btn_mode = 1'b0;
    logic [3:0] gray_out;
    logic       gray_upd;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // Gray codes of binary 5,6,...,15,0,...,9 (walk starting from binary 4).
    logic [3:0] walk [21] = '{4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101,
                              4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                              4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                              4'b1101};

    gray_input_controller #(.DB_CNT(DB), .STEP_CNT(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_gray  (sw_gray),
        .btn_mode (btn_mode),
        .gray_out (gray_out),
        .gray_upd (gray_upd),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (gray_out !== 4'b0000) begin errors++; $display("FAIL reset_gray: got %b want 0000", gray_out); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", mode); end
        checks++; if (gray_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", gray_upd); end
        rst = 1'b0;
        sw_gray = 4'b0101;
        step(10);
        checks++; if (gray_out !== 4'b0101) begin errors++; $display("FAIL pre_reset_gray: got %b want 0101", gray_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gray_out !== 4'b0000) begin errors++; $display("FAIL midrun_reset_gray: got %b want 0000", gray_out); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL midrun_reset_mode: got %b want 00", mode); end
        sw_gray = 4'b0000;
        step(2);
        rst = 1'b0;
        step(8);
        checks++; if (gray_out !== 4'b0000) begin errors++; $display("FAIL post_reset_gray: got %b want 0000", gray_out); end
    endtask

    task automatic test_manual;
        sw_gray = 4'b0110;
        for (int i = 1; i <= 2 + DB - 1; i++) begin
            step(1);
            checks++; if (gray_out !== 4'b0000 || gray_upd !== 1'b0) begin errors++; $display("FAIL manual_early edge %0d: got %b/%b want 0000/0", i, gray_out, gray_upd); end
        end
        step(1);
        checks++; if (gray_out !== 4'b0110) begin errors++; $display("FAIL manual_gray: got %b want 0110", gray_out); end
        checks++; if (gray_upd !== 1'b1) begin errors++; $display("FAIL manual_upd: got %b want 1", gray_upd); end
        for (int i = 0; i < 6; i++) begin
            step(1);
            checks++; if (gray_upd !== 1'b0 || gray_out !== 4'b0110) begin errors++; $display("FAIL manual_single_pulse: got %b/%b want 0110/0", gray_out, gray_upd); end
        end
    endtask

    task automatic test_debounce;
        for (int t = 0; t < 7; t++) begin
            sw_gray = (t % 2 == 0) ? 4'b0011 : 4'b0010;
            for (int i = 0; i < 3; i++) begin
                step(1);
                checks++; if (gray_out !== 4'b0110 || gray_upd !== 1'b0) begin errors++; $display("FAIL debounce_glitch: got %b/%b want 0110/0", gray_out, gray_upd); end
            end
        end
        sw_gray = 4'b0010;
        step(5);
        checks++; if (gray_out !== 4'b0110) begin errors++; $display("FAIL debounce_hold_early: got %b want 0110", gray_out); end
        step(1);
        checks++; if (gray_out !== 4'b0010 || gray_upd !== 1'b1) begin errors++; $display("FAIL debounce_accept: got %b/%b want 0010/1", gray_out, gray_upd); end
    endtask

    task automatic test_auto_walk;
        sw_gray = 4'b0110;
        step(6);
        checks++; if (gray_out !== 4'b0110) begin errors++; $display("FAIL auto_start_gray: got %b want 0110", gray_out); end
        btn_mode = 1'b1;
        step(6);
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL auto_mode_early: got %b want 00", mode); end
        step(1);
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL auto_mode: got %b want 01", mode); end
        btn_mode = 1'b0;
        for (int s = 0; s < 21; s++) begin
            step(ST - 1);
            checks++; if (gray_upd !== 1'b0 || gray_out !== ((s == 0) ? 4'b0110 : walk[s-1])) begin errors++; $display("FAIL auto_between step %0d: got %b/%b", s, gray_out, gray_upd); end
            step(1);
            checks++; if (gray_out !== walk[s] || gray_upd !== 1'b1 || mode !== 2'b01) begin errors++; $display("FAIL auto_step %0d: got %b/%b/%b want %b/1/01", s, gray_out, gray_upd, mode, walk[s]); end
        end
    endtask

    task automatic test_hold;
        btn_mode = 1'b1;
        step(7);
        checks++; if (mode !== 2'b10 || gray_out !== 4'b1101) begin errors++; $display("FAIL hold_entry: got %b/%b want 10/1101", mode, gray_out); end
        btn_mode = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) sw_gray = 4'b1010;
            step(1);
            checks++; if (gray_out !== 4'b1101 || gray_upd !== 1'b0 || mode !== 2'b10) begin errors++; $display("FAIL hold_frozen cycle %0d: got %b/%b/%b want 1101/0/10", i, gray_out, gray_upd, mode); end
        end
    endtask

    task automatic test_return_manual;
        btn_mode = 1'b1;
        step(7);
        checks++; if (mode !== 2'b00 || gray_out !== 4'b1101 || gray_upd !== 1'b0) begin errors++; $display("FAIL return_entry: got %b/%b/%b want 00/1101/0", mode, gray_out, gray_upd); end
        btn_mode = 1'b0;
        step(1);
        checks++; if (gray_out !== 4'b1010 || gray_upd !== 1'b1) begin errors++; $display("FAIL return_follow: got %b/%b want 1010/1", gray_out, gray_upd); end
        step(1);
        checks++; if (gray_upd !== 1'b0) begin errors++; $display("FAIL return_pulse_width: got %b want 0", gray_upd); end
    endtask

    task automatic test_collision;
        step(8);
        btn_mode = 1'b1;
        step(7);
        checks++; if (mode !== 2'b01 || gray_out !== 4'b1010) begin errors++; $display("FAIL coll_auto_entry: got %b/%b want 01/1010", mode, gray_out); end
        btn_mode = 1'b0;
        step(ST);
        checks++; if (gray_out !== 4'b1011 || gray_upd !== 1'b1) begin errors++; $display("FAIL coll_first_step: got %b/%b want 1011/1", gray_out, gray_upd); end
        step(1);
        btn_mode = 1'b1;
        step(6);
        checks++; if (mode !== 2'b01 || gray_out !== 4'b1011) begin errors++; $display("FAIL coll_pre: got %b/%b want 01/1011", mode, gray_out); end
        step(1);
        checks++; if (mode !== 2'b10 || gray_out !== 4'b1011 || gray_upd !== 1'b0) begin errors++; $display("FAIL coll_edge: got %b/%b/%b want 10/1011/0", mode, gray_out, gray_upd); end
        btn_mode = 1'b0;
        step(ST);
        checks++; if (gray_out !== 4'b1011 || mode !== 2'b10) begin errors++; $display("FAIL coll_after: got %b/%b want 1011/10", gray_out, mode); end
    endtask

    initial begin
        test_reset;
        test_manual;
        test_debounce;
        test_auto_walk;
        test_hold;
        test_return_manual;
        test_collision;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
